tabellone_morra: RTL
====================

# tabellone_morra

Result scoreboard sitting directly downstream of the Morra Cinese game FSM. Samples the FSM's per-cycle `MANCHE` and `PARTITA` codes and keeps per-match manche tallies and cumulative match totals. Presents each finished match's outcome to a display/host consumer through a valid/ack handshake, and flags protocol anomalies from the game FSM.

## Interface
Parameters:
- `W_MANCHE`, 5: width of per-match manche counters; the legal maximum of 19 manche fits.
- `W_TOT`, 8: width of cumulative match counters.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `INIZIO`  in  1  match start; the same signal that drives the game FSM.
- `MANCHE`  in  2  manche result: 00 none/invalid, 01 player 1, 10 player 2, 11 draw.
- `PARTITA`  in  2  match result, same encoding; 00 means match still running.
- `ack`  in  1  consumer has read `esito`.
- `punti1`, `punti2`, `pareggi`  out  W_MANCHE each  manche won by player 1, won by player 2, and drawn, in the current or last match.
- `manche_tot`  out  W_MANCHE  valid manche played in the current or last match.
- `vittorie1`, `vittorie2`, `patte`  out  W_TOT each  cumulative matches won by player 1, won by player 2, and drawn.
- `esito`  out  2  last match result.
- `esito_valid`  out  1  `esito` holds an unread result.
- `overrun`  out  1  sticky; a result was overwritten before it was acked.
- `errore`  out  1  sticky; a protocol violation was seen on `MANCHE`/`PARTITA`.

## Operation
- Reset (`rst_n`=0, asynchronous): all outputs 0; state goes to ATTESA.
- States:
  - ATTESA: idle after reset or ack.
  - GIOCO: match running.
  - CHIUSA: match ended, per-match counters frozen.
- `INIZIO`=1 takes priority in every state:
  - clears `punti1`, `punti2`, `pareggi`, `manche_tot`;
  - next state is GIOCO;
  - `MANCHE`/`PARTITA` are ignored that cycle;
  - cumulative counters, `esito`, `esito_valid` and the sticky flags are untouched.
- An aborted match (`INIZIO` during GIOCO) is never recorded in the cumulative counters.
- GIOCO with `INIZIO`=0:
  - `MANCHE`=01, 10 or 11 increments `punti1`, `punti2` or `pareggi` respectively, plus `manche_tot`.
  - `MANCHE`=00: no change.
  - `PARTITA`≠00 ends the match:
    - the current `MANCHE` is counted;
    - `esito` ← `PARTITA`;
    - `vittorie1`, `vittorie2` or `patte` increments according to `PARTITA`;
    - `esito_valid` ← 1;
    - next state is CHIUSA.
  - `PARTITA`≠00 with `MANCHE`≠`PARTITA` sets `errore`; the match is still recorded as above.
- ATTESA/CHIUSA with `INIZIO`=0:
  - `MANCHE`/`PARTITA` are ignored;
  - any nonzero value sets `errore`.
- Handshake:
  - `esito_valid` stays 1 until the first cycle with `ack`=1;
  - it clears on that edge;
  - `ack` with CHIUSA and `INIZIO`=0 moves the state to ATTESA;
  - `ack` while `esito_valid`=0 is ignored.
- Match end while `esito_valid`=1 and `ack`=0:
  - `esito` is overwritten;
  - `esito_valid` stays 1;
  - `overrun` ← 1.
- Match end in the same cycle as `ack`:
  - the new result is loaded;
  - `esito_valid` stays 1;
  - no overrun.
- Arithmetic: every counter saturates at all-ones and never wraps. Only the cumulative counters can saturate in legal use.
- Sticky flags (`overrun`, `errore`) clear only on reset.

## Timing
- All outputs are registered.
- Latency is 1 cycle: a code sampled on edge N is visible on the outputs after edge N.
- `esito`, `esito_valid` and the cumulative counters update on the same edge as the final manche count.
- `ack` takes effect on its sampling edge; `esito_valid` is low the cycle after.
- Reset asserted mid-match clears everything immediately, without waiting for the clock edge.
- Reset release is synchronous to `clk`; the first update occurs on the first edge with `rst_n`=1.

## Structure
- Shared package `morra_pkg` holds:
  - result encodings: `ESITO_NESSUNO`=00, `ESITO_G1`=01, `ESITO_G2`=10, `ESITO_PARI`=11;
  - state enum `stato_tab_t` {ATTESA, GIOCO, CHIUSA};
  - defaults for `W_MANCHE` and `W_TOT`.
- One sub-module, `contatore_sat`: a parameterized width counter with inputs clear, enable and async `rst_n`, saturating. It is instantiated 7 times.
- FSM, handshake and flag logic live in the top module.

## Test plan
- Normal match, player 1 wins: reset, `INIZIO` pulse, then `MANCHE` 01,11,01,00,01,01 with `PARTITA`=01 on the last cycle.
  - Expect `punti1`=4, `pareggi`=1, `manche_tot`=5.
  - Expect `esito`=01, `esito_valid`=1, `vittorie1`=1.
  - `ack` → `esito_valid`=0, state ATTESA.
- Overrun: finish a match with `PARTITA`=10 and no ack, then `INIZIO` and a second match ending with `PARTITA`=11.
  - Expect `esito`=11, `overrun`=1, `vittorie2`=1, `patte`=1.
- Ack coincident with match end: `ack`=1 in the same cycle as `PARTITA`=01.
  - Expect `esito_valid`=1, `esito`=01, `overrun`=0.
- Protocol errors:
  - `MANCHE`=10 in ATTESA → `errore`=1, counters unchanged.
  - `PARTITA`=01 with `MANCHE`=10 → `errore`=1, `vittorie1` increments.
- Abort and reset:
  - `INIZIO` mid-match after 3 manche → per-match counters 0, cumulative unchanged.
  - `rst_n` low mid-cycle → all outputs 0 before the next edge.
- Saturation: force 256 player-2 match wins → `vittorie2` holds at 255.

Source files
------------

// File: rtl/tabellone_morra_pkg.sv
// -----------------------------------------------------------------------------
// morra_pkg
// Shared definitions for the Morra Cinese result scoreboard.
//   - ESITO_* : 2-bit result encodings used on MANCHE, PARTITA and esito
//   - stato_tab_t : scoreboard state (ATTESA, GIOCO, CHIUSA)
//   - W_MANCHE_DEF / W_TOT_DEF : default counter widths
//   - is_valido() : true for any code other than "none"
// -----------------------------------------------------------------------------
package morra_pkg;

  localparam logic [1:0] ESITO_NESSUNO = 2'b00;
  localparam logic [1:0] ESITO_G1      = 2'b01;
  localparam logic [1:0] ESITO_G2      = 2'b10;
  localparam logic [1:0] ESITO_PARI    = 2'b11;

  typedef enum logic [1:0] {
    ATTESA = 2'd0,
    GIOCO  = 2'd1,
    CHIUSA = 2'd2
  } stato_tab_t;

  // 19 manche at most in a legal match, so 5 bits are enough per match.
  localparam int W_MANCHE_DEF = 5;
  localparam int W_TOT_DEF    = 8;

  function automatic logic is_valido(input logic [1:0] codice);
    return codice != ESITO_NESSUNO;
  endfunction

endpackage

// File: rtl/tabellone_morra_contatore_sat.sv
// -----------------------------------------------------------------------------
// contatore_sat
// Up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk    in  1  clock
//   rst_n  in  1  asynchronous active-low reset (counter to 0)
//   i_clr  in  1  synchronous clear, wins over i_en
//   i_en   in  1  count enable
//   o_cnt  out W  current count (registered)
// -----------------------------------------------------------------------------
module contatore_sat #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  localparam logic [W-1:0] UNO = W'(1);

  logic [W-1:0] r_cnt;
  logic         w_pieno;

  assign w_pieno = &r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !w_pieno) begin
      r_cnt <= r_cnt + UNO;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/tabellone_morra.sv
// -----------------------------------------------------------------------------
// tabellone_morra
// Result scoreboard downstream of the Morra Cinese game FSM. Tallies manche
// within a match, keeps cumulative match totals, hands each finished match
// result to a consumer via esito/esito_valid/ack, and flags protocol anomalies.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   INIZIO           match start (clears per-match tallies)
//   MANCHE, PARTITA  per-cycle manche / match result codes from the game FSM
//   ack              consumer has read esito
//   punti1, punti2, pareggi, manche_tot   per-match tallies (W_MANCHE)
//   vittorie1, vittorie2, patte           cumulative match totals (W_TOT)
//   esito, esito_valid                    last match result and its valid flag
//   overrun          sticky: unread result overwritten
//   errore           sticky: protocol violation on MANCHE/PARTITA
// -----------------------------------------------------------------------------
module tabellone_morra
  import morra_pkg::*;
#(
  parameter int W_MANCHE = W_MANCHE_DEF,
  parameter int W_TOT    = W_TOT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                INIZIO,
  input  logic [1:0]          MANCHE,
  input  logic [1:0]          PARTITA,
  input  logic                ack,
  output logic [W_MANCHE-1:0] punti1,
  output logic [W_MANCHE-1:0] punti2,
  output logic [W_MANCHE-1:0] pareggi,
  output logic [W_MANCHE-1:0] manche_tot,
  output logic [W_TOT-1:0]    vittorie1,
  output logic [W_TOT-1:0]    vittorie2,
  output logic [W_TOT-1:0]    patte,
  output logic [1:0]          esito,
  output logic                esito_valid,
  output logic                overrun,
  output logic                errore
);

  // Index map of the per-match counter bank: 0 G1, 1 G2, 2 draws, 3 total.
  localparam int N_MANCHE = 4;
  // Index map of the cumulative bank: 0 G1, 1 G2, 2 draws.
  localparam int N_TOT    = 3;

  stato_tab_t r_stato;
  logic [1:0] r_esito;
  logic       r_esito_valid;
  logic       r_overrun;
  logic       r_errore;

  logic                w_conta;      // a manche code is accepted this cycle
  logic                w_fine;       // the match ends this cycle
  logic                w_err_fine;   // match end with inconsistent final manche
  logic                w_err_fermo;  // activity while no match is running
  logic                w_ack_eff;    // ack that actually consumes a result
  logic [N_MANCHE-1:0] w_en_manche;
  logic [N_TOT-1:0]    w_en_tot;
  logic [W_MANCHE-1:0] w_cnt_manche [N_MANCHE];
  logic [W_TOT-1:0]    w_cnt_tot    [N_TOT];

  // INIZIO masks MANCHE/PARTITA in every state, so everything below is
  // qualified with !INIZIO.
  assign w_conta     = (r_stato == GIOCO) && !INIZIO;
  assign w_fine      = w_conta && is_valido(PARTITA);
  assign w_err_fine  = w_fine && (MANCHE != PARTITA);
  assign w_err_fermo = (r_stato != GIOCO) && !INIZIO &&
                       (is_valido(MANCHE) || is_valido(PARTITA));
  assign w_ack_eff   = ack && r_esito_valid;

  // Per-match enables: the final manche is counted on the match-end edge too.
  assign w_en_manche[0] = w_conta && (MANCHE == ESITO_G1);
  assign w_en_manche[1] = w_conta && (MANCHE == ESITO_G2);
  assign w_en_manche[2] = w_conta && (MANCHE == ESITO_PARI);
  assign w_en_manche[3] = w_conta && is_valido(MANCHE);

  // Cumulative enables fire only on a real match end, never on an abort.
  assign w_en_tot[0] = w_fine && (PARTITA == ESITO_G1);
  assign w_en_tot[1] = w_fine && (PARTITA == ESITO_G2);
  assign w_en_tot[2] = w_fine && (PARTITA == ESITO_PARI);

  genvar gi;
  generate
    for (gi = 0; gi < N_MANCHE; gi++) begin : g_manche
      contatore_sat #(
        .W (W_MANCHE)
      ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (INIZIO),
        .i_en  (w_en_manche[gi]),
        .o_cnt (w_cnt_manche[gi])
      );
    end
    for (gi = 0; gi < N_TOT; gi++) begin : g_tot
      contatore_sat #(
        .W (W_TOT)
      ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (1'b0),
        .i_en  (w_en_tot[gi]),
        .o_cnt (w_cnt_tot[gi])
      );
    end
  endgenerate

  // State, handshake and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stato       <= ATTESA;
      r_esito       <= ESITO_NESSUNO;
      r_esito_valid <= 1'b0;
      r_overrun     <= 1'b0;
      r_errore      <= 1'b0;
    end else begin
      if (w_err_fine || w_err_fermo) begin
        r_errore <= 1'b1;
      end

      // A new result always wins over ack: the consumer read the old one in
      // the same cycle, so valid stays high without an overrun.
      if (w_fine) begin
        r_esito       <= PARTITA;
        r_esito_valid <= 1'b1;
        if (r_esito_valid && !ack) begin
          r_overrun <= 1'b1;
        end
      end else if (w_ack_eff) begin
        r_esito_valid <= 1'b0;
      end

      case (r_stato)
        ATTESA: begin
          if (INIZIO) begin
            r_stato <= GIOCO;
          end
        end
        GIOCO: begin
          if (INIZIO) begin
            r_stato <= GIOCO;
          end else if (w_fine) begin
            r_stato <= CHIUSA;
          end
        end
        CHIUSA: begin
          if (INIZIO) begin
            r_stato <= GIOCO;
          end else if (w_ack_eff) begin
            r_stato <= ATTESA;
          end
        end
        default: begin
          r_stato <= ATTESA;
        end
      endcase
    end
  end

  assign punti1      = w_cnt_manche[0];
  assign punti2      = w_cnt_manche[1];
  assign pareggi     = w_cnt_manche[2];
  assign manche_tot  = w_cnt_manche[3];
  assign vittorie1   = w_cnt_tot[0];
  assign vittorie2   = w_cnt_tot[1];
  assign patte       = w_cnt_tot[2];
  assign esito       = r_esito;
  assign esito_valid = r_esito_valid;
  assign overrun     = r_overrun;
  assign errore      = r_errore;

endmodule
